// File: rtl/mux_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_pipe_if
// Brief    : Request/result handshake bundle for the pipelined mux tree.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_pipe_if #(
   parameter int SEL_BITS = 3,
   parameter int WIDTH    = 8
);
   logic                           in_valid;
   logic                           in_ready;
   logic [(2**SEL_BITS)*WIDTH-1:0] in_data;
   logic [SEL_BITS-1:0]            in_sel;
   logic                           out_valid;
   logic                           out_ready;
   logic [WIDTH-1:0]               out_data;
   logic [SEL_BITS-1:0]            out_sel;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

`default_nettype wire

// File: rtl/mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_pipe
// Brief    : Binary mux tree of SEL_BITS registered levels with valid/ready
//            flow control. Define MUX_PIPE_ZERO_BUBBLE_EN to zero the data
//            and select fields of bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module mux_pipe #(
   parameter int SEL_BITS = 3,
   parameter int WIDTH    = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   mux_pipe_if.slave bus
);

   logic w_stall;
   logic w_advance;

   assign w_stall      = bus.out_valid & ~bus.out_ready;
   assign w_advance    = ~w_stall;
   assign bus.in_ready = w_advance;

   for (genvar k = 0; k < SEL_BITS; k++) begin : g_level
      localparam int c_words = 2**(SEL_BITS-1-k);

      logic [2*c_words*WIDTH-1:0] w_prev_data;
      logic [SEL_BITS-1:0]        w_prev_sel;
      logic                       w_prev_valid;
      logic [c_words*WIDTH-1:0]   w_red;
      logic [c_words*WIDTH-1:0]   r_data;
      // Full original select; bits above k are the ones later levels consume.
      logic [SEL_BITS-1:0]        r_sel;
      logic                       r_valid;

      if (k == 0) begin : g_src_in
         assign w_prev_data  = bus.in_data;
         assign w_prev_sel   = bus.in_sel;
         assign w_prev_valid = bus.in_valid;
      end else begin : g_src_lvl
         assign w_prev_data  = g_level[k-1].r_data;
         assign w_prev_sel   = g_level[k-1].r_sel;
         assign w_prev_valid = g_level[k-1].r_valid;
      end

      always_comb begin
         w_red = '0;
         for (int j = 0; j < c_words; j++) begin
            w_red[j*WIDTH +: WIDTH] = w_prev_sel[k] ? w_prev_data[(2*j+1)*WIDTH +: WIDTH]
                                                    : w_prev_data[(2*j)*WIDTH +: WIDTH];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
         end else if (w_advance) begin
            r_valid <= w_prev_valid;
`ifdef MUX_PIPE_ZERO_BUBBLE_EN
            r_data  <= w_prev_valid ? w_red : '0;
            r_sel   <= w_prev_valid ? w_prev_sel : '0;
`else
            // Payload only moves with a real request, so idle outputs stay quiet.
            if (w_prev_valid) begin
               r_data <= w_red;
               r_sel  <= w_prev_sel;
            end
`endif
         end
      end
   end

   assign bus.out_valid = g_level[SEL_BITS-1].r_valid;
   assign bus.out_data  = g_level[SEL_BITS-1].r_data;
   assign bus.out_sel   = g_level[SEL_BITS-1].r_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_pipe
// Brief    : Scoreboard bench for mux_pipe (3/8 main instance, 1/1 and 6/64
//            corner instances) with a word-indexing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_pipe;
   localparam int SB  = 3;
   localparam int W   = 8;
   localparam int TOT = (2**SB)*W;

   logic clk;
   logic rst_n;
   logic rst_n_c;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   stall_cnt = 0;

   typedef struct {
      logic [W-1:0]  data;
      logic [SB-1:0] sel;
      int            cyc;
      int            stalls;
   } ent_t;

   ent_t          sb[$];
   logic [W-1:0]  last_data;
   logic [SB-1:0] last_sel;
   logic [TOT-1:0] words_a;

   mux_pipe_if #(.SEL_BITS(SB), .WIDTH(W)) bus ();
   mux_pipe #(.SEL_BITS(SB), .WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [TOT-1:0] rand_words();
      logic [TOT-1:0] d;
      for (int b = 0; b < TOT; b++) d[b] = 1'($urandom);
      return d;
   endfunction

   // Drive one cycle; record the expected result if the request is taken.
   task automatic drive(input logic v, input logic [SB-1:0] s, input logic [TOT-1:0] d,
                        input logic rdy, output logic acc);
      ent_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = rdy;
      #1;
      acc = rst_n && bus.in_valid && bus.in_ready;
      if (acc) begin
         e.data   = d[int'(s)*W +: W];
         e.sel    = s;
         e.cyc    = cyc;
         e.stalls = stall_cnt;
         sb.push_back(e);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", bus.out_valid, 0);
            end else begin
               chk("out_data", bus.out_data, sb[0].data);
               chk("out_sel", bus.out_sel, sb[0].sel);
               if (bus.out_ready) begin
                  chk("latency", cyc - sb[0].cyc, SB + stall_cnt - sb[0].stalls);
                  last_data = sb[0].data;
                  last_sel  = sb[0].sel;
                  void'(sb.pop_front());
               end else begin
                  stall_cnt++;
               end
            end
         end else begin
`ifdef MUX_PIPE_ZERO_BUBBLE_EN
            chk("idle_out_data", bus.out_data, 0);
            chk("idle_out_sel", bus.out_sel, 0);
`else
            chk("idle_out_data", bus.out_data, last_data);
            chk("idle_out_sel", bus.out_sel, last_sel);
`endif
         end
      end
   end

   // Corner parameter sets run alongside the main instance with out_ready=1.
   for (genvar gi = 0; gi < 2; gi++) begin : g_corner
      localparam int c_sb  = (gi == 0) ? 1 : 6;
      localparam int c_w   = (gi == 0) ? 1 : 64;
      localparam int c_tot = (2**c_sb)*c_w;

      typedef struct {
         logic [63:0] data;
         logic [5:0]  sel;
         int          cyc;
      } ce_t;

      ce_t q[$];
      ce_t ce;
      ce_t co;

      mux_pipe_if #(.SEL_BITS(c_sb), .WIDTH(c_w)) cbus ();
      mux_pipe #(.SEL_BITS(c_sb), .WIDTH(c_w)) u_dut (.clk(clk), .rst_n(rst_n_c), .bus(cbus));

      initial begin
         cbus.in_valid  = 1'b0;
         cbus.in_sel    = '0;
         cbus.in_data   = '0;
         cbus.out_ready = 1'b1;
         wait (rst_n_c);
         for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            cbus.in_valid = ($urandom_range(0, 3) != 0);
            cbus.in_sel   = c_sb'($urandom);
            for (int b = 0; b < c_tot; b++) cbus.in_data[b] = 1'($urandom);
            #1;
            if (cbus.in_valid && cbus.in_ready) begin
               ce.data = 64'(cbus.in_data[int'(cbus.in_sel)*c_w +: c_w]);
               ce.sel  = 6'(cbus.in_sel);
               ce.cyc  = cyc;
               q.push_back(ce);
            end
         end
         @(negedge clk);
         cbus.in_valid = 1'b0;
      end

      always @(negedge clk) begin
         #1;
         if (rst_n_c && cbus.out_valid) begin
            if (q.size() == 0) begin
               chk("corner_spurious", cbus.out_valid, 0);
            end else begin
               co = q.pop_front();
               chk("corner_data", 64'(cbus.out_data), co.data);
               chk("corner_sel", 64'(cbus.out_sel), 64'(co.sel));
               chk("corner_latency", cyc - co.cyc, c_sb);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   seq;
      rst_n = 1'b0;
      rst_n_c = 1'b0;
      last_data = '0;
      last_sel  = '0;
      bus.in_valid  = 1'b0;
      bus.in_sel    = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2**SB; i++) words_a[i*W +: W] = 8'hA0 + 8'(i);

      #12;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_out_data", bus.out_data, 0);
      chk("reset_out_sel", bus.out_sel, 0);
      chk("reset_in_ready", bus.in_ready, 1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      rst_n_c = 1'b1;

      // Single request: select 5 of A0..A7
      drive(1, 3'd5, words_a, 1, acc);
      chk("basic_accept", acc, 1);
      repeat (5) drive(0, '0, '0, 1, acc);

      // Back-to-back stream over every index
      for (int i = 0; i < 2**SB; i++) drive(1, SB'(i), words_a, 1, acc);
      repeat (5) drive(0, '0, '0, 1, acc);

      // Stream under a 4-cycle consumer stall
      seq = 0;
      for (int c = 0; c < 16; c++) begin
         drive(1, SB'(seq), words_a, !(c >= 3 && c < 7), acc);
         if (acc) seq++;
      end
      repeat (6) drive(0, '0, '0, 1, acc);

      // Alternating request/bubble
      for (int i = 0; i < 10; i++) drive(i % 2 == 0, SB'($urandom), rand_words(), 1, acc);
      repeat (5) drive(0, SB'($urandom), rand_words(), 1, acc);

      // Random traffic with random backpressure
      for (int i = 0; i < 200; i++)
         drive($urandom_range(0, 3) != 0, SB'($urandom), rand_words(),
               $urandom_range(0, 9) < 7, acc);
      repeat (8) drive(0, '0, '0, 1, acc);

      // Asynchronous reset with three requests in flight
      for (int i = 0; i < 3; i++) drive(1, SB'(i + 2), words_a, 1, acc);
      @(posedge clk); #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_data", bus.out_data, 0);
      chk("midrst_out_sel", bus.out_sel, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      sb.delete();
      last_data = '0;
      last_sel  = '0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      drive(1, 3'd7, words_a, 1, acc);
      chk("first_accept_after_reset", acc, 1);
      repeat (10) drive(0, '0, '0, 1, acc);

      for (int i = 0; i < 50 && sb.size() != 0; i++) drive(0, '0, '0, 1, acc);
      chk("drain", sb.size(), 0);
      chk("corner0_drain", g_corner[0].q.size(), 0);
      chk("corner1_drain", g_corner[1].q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
